sid_adsr_multi: RTL and testbench

Multi-voice, parametrised ADSR envelope generator. It is the successor to the single-voice 4-bit linear envelope. It provides NUM_VOICES independent envelopes of ENV_WIDTH bits each, with an optional SID-style piecewise-exponential decay/release. It also retriggers attack from the current level rather than from zero. It sits between the voice register file and the per-voice amplitude multipliers, and is driven by the shared free-running prescaler.

---
 rtl/sid_adsr_multi.sv | 172 +++++++++++++++++
 tb/tb_sid_adsr_multi.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sid_adsr_multi.sv
// sid_adsr_multi
// Multi-voice ADSR envelope generator. Each voice runs an independent
// IDLE/ATTACK/DECAY/RELEASE state machine with linear attack and either
// linear or SID-style piecewise-exponential decay/release. Attack retriggers
// from the current level. Time steps come from a shared free-running
// prescaler; a rate N ticks when prescaler bits [N+RATE_BASE:0] are all ones.
//
// Ports:
//   clk           system clock, all state on posedge
//   rst           synchronous active-high reset
//   gate          per-voice gate, bit v = voice v
//   attack_rate   per-voice attack rate nibble
//   decay_rate    per-voice decay rate nibble
//   sustain_value per-voice sustain level nibble
//   release_rate  per-voice release rate nibble
//   prescaler     shared free-running counter
//   env_out       per-voice envelope level, slice v = voice v
//   env_state     per-voice state: 0 IDLE, 1 ATTACK, 2 DECAY, 3 RELEASE
module sid_adsr_multi #(
    parameter int NUM_VOICES      = 3,
    parameter int ENV_WIDTH       = 8,
    parameter int PRESCALER_WIDTH = 23,
    parameter int RATE_BASE       = 8,
    parameter int EXP_DECAY       = 1
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_VOICES-1:0]           gate,
    input  logic [4*NUM_VOICES-1:0]         attack_rate,
    input  logic [4*NUM_VOICES-1:0]         decay_rate,
    input  logic [4*NUM_VOICES-1:0]         sustain_value,
    input  logic [4*NUM_VOICES-1:0]         release_rate,
    input  logic [PRESCALER_WIDTH-1:0]      prescaler,
    output logic [ENV_WIDTH*NUM_VOICES-1:0] env_out,
    output logic [2*NUM_VOICES-1:0]         env_state
);
    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_ATTACK  = 2'd1;
    localparam logic [1:0] ST_DECAY   = 2'd2;
    localparam logic [1:0] ST_RELEASE = 2'd3;

    localparam logic [ENV_WIDTH-1:0] LVL_MAX  = {ENV_WIDTH{1'b1}};
    localparam logic [ENV_WIDTH-1:0] LVL_ZERO = {ENV_WIDTH{1'b0}};
    localparam logic [ENV_WIDTH-1:0] LVL_ONE  = {{(ENV_WIDTH-1){1'b0}}, 1'b1};

    genvar gi;
    generate
        for (gi = 0; gi < NUM_VOICES; gi++) begin : g_voice
            logic [1:0]           state_reg, state_next;
            logic [ENV_WIDTH-1:0] level_reg, level_next;
            logic [3:0]           exp_cnt_reg, exp_cnt_next;
            logic                 last_gate_reg;
            logic                 rise;
            logic                 tick;
            logic                 step;
            logic [3:0]           rate_sel;
            logic [3:0]           sus_nib;
            logic [ENV_WIDTH-1:0] sus_level;
            logic [4:0]           divisor;
            logic [3:0]           cnt_adv;

            assign sus_nib = sustain_value[4*gi +: 4];
            assign rise    = gate[gi] & ~last_gate_reg;

            // Sustain nibble repeated from the MSB down, so 0xA -> 0xAA.
            always_comb begin
                for (int b = 0; b < ENV_WIDTH; b++) begin
                    sus_level[ENV_WIDTH-1-b] = sus_nib[3 - (b % 4)];
                end
            end

            always_comb begin
                case (state_reg)
                    ST_ATTACK:  rate_sel = attack_rate[4*gi +: 4];
                    ST_DECAY:   rate_sel = decay_rate[4*gi +: 4];
                    ST_RELEASE: rate_sel = release_rate[4*gi +: 4];
                    default:    rate_sel = 4'd0;
                endcase
            end

            // Tick when every prescaler bit up to the (clamped) rate index is set.
            always_comb begin
                int top;
                top = int'(rate_sel) + RATE_BASE;
                if (top > PRESCALER_WIDTH - 1) begin
                    top = PRESCALER_WIDTH - 1;
                end
                tick = 1'b1;
                for (int b = 0; b < PRESCALER_WIDTH; b++) begin
                    if (b <= top) begin
                        tick = tick & prescaler[b];
                    end
                end
            end

            // Level >= MAX/2^k + 1 is exactly "one of the top k bits is set".
            always_comb begin
                if (level_reg[ENV_WIDTH-1])      divisor = 5'd1;
                else if (level_reg[ENV_WIDTH-2]) divisor = 5'd2;
                else if (level_reg[ENV_WIDTH-3]) divisor = 5'd4;
                else if (level_reg[ENV_WIDTH-4]) divisor = 5'd8;
                else                             divisor = 5'd16;
            end

            // In linear mode every tick steps, which also keeps exp_cnt at 0.
            assign step = (EXP_DECAY == 0) ? tick
                        : (tick && (({1'b0, exp_cnt_reg} + 5'd1) == divisor));
            assign cnt_adv = step ? 4'd0 : (exp_cnt_reg + 4'd1);

            // State register
            always_ff @(posedge clk) begin
                if (rst) begin
                    state_reg     <= ST_IDLE;
                    level_reg     <= LVL_ZERO;
                    exp_cnt_reg   <= 4'd0;
                    last_gate_reg <= 1'b0;
                end else begin
                    state_reg     <= state_next;
                    level_reg     <= level_next;
                    exp_cnt_reg   <= exp_cnt_next;
                    last_gate_reg <= gate[gi];
                end
            end

            // Next-state logic
            always_comb begin
                state_next   = state_reg;
                level_next   = level_reg;
                exp_cnt_next = exp_cnt_reg;
                case (state_reg)
                    ST_IDLE: begin
                        level_next = LVL_ZERO;
                        if (rise) state_next = ST_ATTACK;
                    end
                    ST_ATTACK: begin
                        if (!gate[gi])              state_next = ST_RELEASE;
                        else if (level_reg == LVL_MAX) state_next = ST_DECAY;
                        else if (tick)              level_next = level_reg + LVL_ONE;
                    end
                    ST_DECAY: begin
                        if (!gate[gi]) begin
                            state_next = ST_RELEASE;
                        end else if (level_reg > sus_level) begin
                            if (tick) exp_cnt_next = cnt_adv;
                            if (step) level_next = level_reg - LVL_ONE;
                        end
                    end
                    default: begin // ST_RELEASE
                        if (rise) begin
                            state_next = ST_ATTACK;
                        end else if (level_reg == LVL_ZERO) begin
                            state_next = ST_IDLE;
                        end else begin
                            if (tick) exp_cnt_next = cnt_adv;
                            if (step) level_next = level_reg - LVL_ONE;
                        end
                    end
                endcase
                // Each decay/release phase starts its divisor count afresh.
                if (state_next != state_reg || state_reg == ST_IDLE
                    || state_reg == ST_ATTACK) begin
                    exp_cnt_next = 4'd0;
                end
            end

            // Output logic: outputs are the registered state directly.
            assign env_out[ENV_WIDTH*gi +: ENV_WIDTH] = level_reg;
            assign env_state[2*gi +: 2]               = state_reg;
        end
    endgenerate

endmodule

// File: tb/tb_sid_adsr_multi.sv
// Testbench for sid_adsr_multi: a linear and an exponential instance share
// the same stimulus. A behavioural model pushes per-cycle expectations and
// directed checkpoints push hand-computed values; a negedge monitor pops and
// compares each entry in the cycle it applies to.
module tb_sid_adsr_multi;
    logic        clk;
    logic        rst;
    logic [2:0]  gate;
    logic [11:0] ar, dr, sr, rr;
    logic [22:0] presc;
    logic [23:0] env_lin, env_exp;
    logic [5:0]  st_lin, st_exp;

    localparam logic [22:0] ALL = 23'h7FFFFF;

    sid_adsr_multi #(.EXP_DECAY(0)) u_lin (
        .clk(clk), .rst(rst), .gate(gate), .attack_rate(ar), .decay_rate(dr),
        .sustain_value(sr), .release_rate(rr), .prescaler(presc),
        .env_out(env_lin), .env_state(st_lin)
    );

    sid_adsr_multi #(.EXP_DECAY(1)) u_exp (
        .clk(clk), .rst(rst), .gate(gate), .attack_rate(ar), .decay_rate(dr),
        .sustain_value(sr), .release_rate(rr), .prescaler(presc),
        .env_out(env_exp), .env_state(st_exp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int    cyc;
        int    dut;
        int    voice;
        int    lvl;
        int    st;
        string name;
    } sb_t;

    sb_t sbq[$];
    int  cyc_cnt = 0;
    int  total = 0;
    int  bad = 0;

    int m_lvl[2][3];
    int m_st[2][3];
    int m_cnt[2][3];
    bit m_last[2][3];

    always @(posedge clk) cyc_cnt = cyc_cnt + 1;

    // Monitor: compare every expectation that applies to the current cycle.
    sb_t         e;
    logic [7:0]  a_lvl;
    logic [1:0]  a_st;
    always @(negedge clk) begin
        while (sbq.size() > 0 && sbq[0].cyc <= cyc_cnt) begin
            e = sbq.pop_front();
            a_lvl = (e.dut == 0) ? env_lin[e.voice*8 +: 8] : env_exp[e.voice*8 +: 8];
            a_st  = (e.dut == 0) ? st_lin[e.voice*2 +: 2]  : st_exp[e.voice*2 +: 2];
            total = total + 1;
            if (int'(a_lvl) != e.lvl || int'(a_st) != e.st) begin
                bad = bad + 1;
                $display("FAIL %s cyc=%0d dut=%0d v=%0d got lvl=%0d st=%0d expected lvl=%0d st=%0d",
                         e.name, cyc_cnt, e.dut, e.voice, a_lvl, a_st, e.lvl, e.st);
            end
        end
    end

    // Behavioural reference: advance one clock using current inputs.
    task automatic model_step();
        for (int d = 0; d < 2; d++) begin
            for (int v = 0; v < 3; v++) begin
                int lvl, st, cnt, nl, nst, nc, rate, top, div, susv;
                longint period;
                bit g, rise, tick;
                lvl = m_lvl[d][v]; st = m_st[d][v]; cnt = m_cnt[d][v];
                g = gate[v];
                rise = g && !m_last[d][v];
                case (st)
                    1: rate = int'(ar[4*v +: 4]);
                    2: rate = int'(dr[4*v +: 4]);
                    3: rate = int'(rr[4*v +: 4]);
                    default: rate = 0;
                endcase
                top = rate + 8;
                if (top > 22) top = 22;
                period = longint'(1) << (top + 1);
                tick = ((longint'(presc) % period) == period - 1);
                susv = int'(sr[4*v +: 4]) * 17;
                div = (lvl >= 128) ? 1 : (lvl >= 64) ? 2 : (lvl >= 32) ? 4 : (lvl >= 16) ? 8 : 16;
                nst = st; nl = lvl; nc = cnt;
                case (st)
                    0: begin nl = 0; if (rise) nst = 1; end
                    1: begin
                        if (!g) nst = 3;
                        else if (lvl == 255) nst = 2;
                        else if (tick) nl = lvl + 1;
                    end
                    2: begin
                        if (!g) nst = 3;
                        else if (lvl > susv && tick) begin
                            if (d == 0 || cnt + 1 == div) begin nl = lvl - 1; nc = 0; end
                            else nc = cnt + 1;
                        end
                    end
                    default: begin
                        if (rise) nst = 1;
                        else if (lvl == 0) nst = 0;
                        else if (tick) begin
                            if (d == 0 || cnt + 1 == div) begin nl = lvl - 1; nc = 0; end
                            else nc = cnt + 1;
                        end
                    end
                endcase
                if (nst != st || nst == 0 || nst == 1) nc = 0;
                if (rst) begin nl = 0; nst = 0; nc = 0; end
                m_lvl[d][v] = nl; m_st[d][v] = nst; m_cnt[d][v] = nc;
                m_last[d][v] = rst ? 1'b0 : g;
                sbq.push_back('{cyc_cnt + 1, d, v, nl, nst, "track"});
            end
        end
    endtask

    task automatic cyc_step();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cyc_step();
    endtask

    // Hand-computed checkpoint for the cycle currently on the outputs.
    task automatic chk(input string name, input int d, input int v, input int lvl, input int st);
        sbq.push_back('{cyc_cnt, d, v, lvl, st, name});
    endtask

    initial begin
        for (int d = 0; d < 2; d++)
            for (int v = 0; v < 3; v++) begin
                m_lvl[d][v] = 0; m_st[d][v] = 0; m_cnt[d][v] = 0; m_last[d][v] = 1'b0;
            end
        rst = 1'b1; gate = 3'b000; ar = 12'h000; dr = 12'h000; sr = 12'h00A;
        rr = 12'h000; presc = 23'd0;
        run(2);
        chk("reset_lin", 0, 0, 0, 0);
        chk("reset_exp", 1, 0, 0, 0);
        rst = 1'b0;

        // 1: attack/decay to sustain 0xAA
        gate = 3'b001;
        run(1);
        chk("t1_rise", 0, 0, 0, 1);
        for (int i = 0; i < 1024; i++) begin
            presc = 23'(i);
            cyc_step();
        end
        chk("t1_free_run", 0, 0, 2, 1);
        presc = ALL;
        run(253);
        chk("t1_max", 0, 0, 255, 1);
        run(1);
        chk("t1_decay_lin", 0, 0, 255, 2);
        chk("t1_decay_exp", 1, 0, 255, 2);
        run(85);
        chk("t1_sus_lin", 0, 0, 170, 2);
        chk("t1_sus_exp", 1, 0, 170, 2);
        run(20);
        chk("t1_hold", 0, 0, 170, 2);

        // 6: reset mid-decay with gate held
        rst = 1'b1;
        run(1);
        chk("t6_rst_lvl", 0, 0, 0, 0);
        chk("t6_rst_exp", 1, 0, 0, 0);
        rst = 1'b0; presc = 23'd0;
        run(1);
        chk("t6_reattack", 0, 0, 0, 1);
        presc = ALL;
        run(100);
        chk("t2_at100_lin", 0, 0, 100, 1);
        chk("t2_at100_exp", 1, 0, 100, 1);

        // 2: gate drop during attack (tick present, no increment)
        gate = 3'b000;
        run(1);
        chk("t2_release", 0, 0, 100, 3);
        chk("t2_release_exp", 1, 0, 100, 3);
        run(100);
        chk("t2_zero_lin", 0, 0, 0, 3);
        chk("t2_mid_exp", 1, 0, 57, 3);
        run(1);
        chk("t2_idle_lin", 0, 0, 0, 0);
        run(600);
        chk("t2_idle_lin2", 0, 0, 0, 0);
        chk("t2_idle_exp", 1, 0, 0, 0);

        // 4: exponential release from 255, sustain 0
        gate = 3'b001;
        run(1);
        chk("t4_rise", 1, 0, 0, 1);
        run(255);
        chk("t4_max", 1, 0, 255, 1);
        run(1);
        chk("t4_decay", 1, 0, 255, 2);
        sr = 12'h000; gate = 3'b000;
        run(1);
        chk("t4_release", 1, 0, 255, 3);
        run(128);
        chk("t4_div1", 1, 0, 127, 3);
        chk("t4_lin127", 0, 0, 127, 3);
        run(128);
        chk("t4_div2", 1, 0, 63, 3);
        chk("t4_lin_idle", 0, 0, 0, 0);
        run(128);
        chk("t4_div4", 1, 0, 31, 3);
        run(128);
        chk("t4_div8", 1, 0, 15, 3);
        run(15);
        chk("t4_div16_hold", 1, 0, 15, 3);
        run(1);
        chk("t4_div16_step", 1, 0, 14, 3);
        run(224);
        chk("t4_zero", 1, 0, 0, 3);
        run(1);
        chk("t4_idle", 1, 0, 0, 0);

        // 3: retrigger during release continues from current level
        gate = 3'b001;
        run(1);
        run(50);
        chk("t3_at50", 0, 0, 50, 1);
        gate = 3'b000;
        run(1);
        run(10);
        chk("t3_rel_lin", 0, 0, 40, 3);
        chk("t3_rel_exp", 1, 0, 48, 3);
        gate = 3'b001;
        run(1);
        chk("t3_retrig", 0, 0, 40, 1);
        run(1);
        chk("t3_next_lin", 0, 0, 41, 1);
        chk("t3_next_exp", 1, 0, 49, 1);
        run(214);
        chk("t3_max", 0, 0, 255, 1);
        run(1);
        chk("t3_decay", 0, 0, 255, 2);

        // 5: independent voices at different attack rates
        rst = 1'b1; gate = 3'b000;
        run(1);
        rst = 1'b0; presc = 23'd0; ar = 12'h300; gate = 3'b110;
        run(1);
        chk("t5_v1_rise", 0, 1, 0, 1);
        chk("t5_v2_rise", 0, 2, 0, 1);
        for (int i = 0; i < 64; i++) begin
            presc = (i % 8 == 7) ? 23'h000FFF : 23'h0001FF;
            cyc_step();
        end
        chk("t5_v1", 0, 1, 64, 1);
        chk("t5_v2", 0, 2, 8, 1);
        chk("t5_v2_exp", 1, 2, 8, 1);
        chk("t5_v0", 0, 0, 0, 0);

        @(posedge clk);
        @(posedge clk);
        #1;
        if (sbq.size() != 0) begin
            total = total + 1;
            bad = bad + 1;
            $display("FAIL drain got %0d pending entries expected 0", sbq.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
